// File: rtl/debounce_scheduler.sv
// debounce_scheduler: round-robin sharing of one debounce timer across N_BUTTONS synchronized inputs
module debounce_scheduler #(
    parameter int N_BUTTONS = 4,
    parameter int DEBOUNCE_TIME = 100,
    localparam int IDX_W = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] real_buttons,
    output logic [N_BUTTONS-1:0] debounced_buttons,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic                 busy,
    output logic [IDX_W-1:0]     active_idx
);
    localparam int CNT_W = $clog2(DEBOUNCE_TIME + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_TIME - 1);
    typedef enum logic {IDLE, COUNT} state_t;
    state_t               state;
    logic [N_BUTTONS-1:0] sync1, sync2, mismatch;
    logic [IDX_W-1:0]     rr_ptr, gnt, nxt;
    logic [CNT_W-1:0]     timer;
    logic                 target, any_mis;
    function automatic int wrap(input int v);
        return v >= N_BUTTONS ? v - N_BUTTONS : v;
    endfunction
    assign mismatch = sync2 ^ debounced_buttons;
    assign nxt = (active_idx == IDX_W'(N_BUTTONS - 1)) ? '0 : active_idx + 1'b1;
    always_comb begin
        any_mis = 1'b0;
        gnt = '0;
        for (int k = 0; k < N_BUTTONS; k++) begin
            if (!any_mis && mismatch[wrap(int'(rr_ptr) + k)]) begin
                any_mis = 1'b1;
                gnt = IDX_W'(wrap(int'(rr_ptr) + k));
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sync1 <= '0;
            sync2 <= '0;
            debounced_buttons <= '0;
            press_pulse <= '0;
            release_pulse <= '0;
            busy <= 1'b0;
            active_idx <= '0;
            rr_ptr <= '0;
            timer <= '0;
            target <= 1'b0;
        end else begin
            sync1 <= real_buttons;
            sync2 <= sync1;
            press_pulse <= '0;
            release_pulse <= '0;
            if (state == IDLE) begin
                if (any_mis) begin
                    state <= COUNT;
                    busy <= 1'b1;
                    active_idx <= gnt;
                    target <= sync2[gnt];
                    timer <= '0;
                end
            end else if (sync2[active_idx] != target || timer == LAST) begin
                // a held level commits; a changed level aborts with no output change
                if (sync2[active_idx] == target) begin
                    debounced_buttons[active_idx] <= target;
                    press_pulse[active_idx] <= target;
                    release_pulse[active_idx] <= ~target;
                end
                state <= IDLE;
                busy <= 1'b0;
                active_idx <= '0;
                rr_ptr <= nxt;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: directed checks of the shared-timer debounce scheduler with N=4, DEBOUNCE_TIME=4
module tb_debounce_scheduler;
    localparam int N = 4;
    localparam int D = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] real_buttons = 4'b0000;
    logic [3:0] debounced_buttons, press_pulse, release_pulse;
    logic       busy;
    logic [1:0] active_idx;
    int         checks = 0;
    int         failures = 0;
    int         press_cnt = 0;
    int         release_cnt = 0;

    debounce_scheduler #(.N_BUTTONS(N), .DEBOUNCE_TIME(D)) dut (
        .clk(clk),
        .rst(rst),
        .real_buttons(real_buttons),
        .debounced_buttons(debounced_buttons),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .busy(busy),
        .active_idx(active_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        press_cnt <= press_cnt + $countones(press_pulse);
        release_cnt <= release_cnt + $countones(release_pulse);
    end

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] v);
        rst = 1'b0;
        real_buttons = v;
        wait_edges(2);
        rst = 1'b1;
        wait_edges(2);
    endtask

    task automatic test_reset();
        int p0;
        real_buttons = 4'b1111;
        rst = 1'b0;
        wait_edges(3);
        checks++; if (debounced_buttons !== 4'b0000) begin failures++; $display("FAIL reset_deb got=%b exp=0000", debounced_buttons); end
        checks++; if (press_pulse !== 4'b0000 || release_pulse !== 4'b0000) begin failures++; $display("FAIL reset_pulse got=%b/%b exp=0000/0000", press_pulse, release_pulse); end
        checks++; if (busy !== 1'b0 || active_idx !== 2'd0) begin failures++; $display("FAIL reset_busy got=%b/%0d exp=0/0", busy, active_idx); end
        p0 = press_cnt;
        rst = 1'b1;
        wait_edges(3);
        checks++; if (busy !== 1'b1 || active_idx !== 2'd0) begin failures++; $display("FAIL rst_grant0 got=%b/%0d exp=1/0", busy, active_idx); end
        wait_edges(4);
        checks++; if (debounced_buttons !== 4'b0001 || press_pulse !== 4'b0001) begin failures++; $display("FAIL rst_commit0 got=%b/%b exp=0001/0001", debounced_buttons, press_pulse); end
        wait_edges(1);
        checks++; if (busy !== 1'b1 || active_idx !== 2'd1) begin failures++; $display("FAIL rst_grant1 got=%b/%0d exp=1/1", busy, active_idx); end
        wait_edges(5);
        checks++; if (busy !== 1'b1 || active_idx !== 2'd2) begin failures++; $display("FAIL rst_grant2 got=%b/%0d exp=1/2", busy, active_idx); end
        wait_edges(5);
        checks++; if (busy !== 1'b1 || active_idx !== 2'd3) begin failures++; $display("FAIL rst_grant3 got=%b/%0d exp=1/3", busy, active_idx); end
        wait_edges(4);
        checks++; if (debounced_buttons !== 4'b1111 || press_pulse !== 4'b1000) begin failures++; $display("FAIL rst_commit3 got=%b/%b exp=1111/1000", debounced_buttons, press_pulse); end
        wait_edges(3);
        checks++; if (press_cnt - p0 !== 4) begin failures++; $display("FAIL rst_press_count got=%0d exp=4", press_cnt - p0); end
    endtask

    task automatic test_clean_press();
        do_reset(4'b0000);
        real_buttons = 4'b0100;
        wait_edges(2);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL press_pre_grant busy=%b exp=0", busy); end
        wait_edges(1);
        checks++; if (busy !== 1'b1 || active_idx !== 2'd2) begin failures++; $display("FAIL press_grant got=%b/%0d exp=1/2", busy, active_idx); end
        wait_edges(3);
        checks++; if (debounced_buttons !== 4'b0000 || press_pulse !== 4'b0000) begin failures++; $display("FAIL press_early got=%b/%b exp=0000/0000", debounced_buttons, press_pulse); end
        wait_edges(1);
        checks++; if (debounced_buttons !== 4'b0100 || press_pulse !== 4'b0100 || release_pulse !== 4'b0000) begin failures++; $display("FAIL press_commit got=%b/%b/%b exp=0100/0100/0000", debounced_buttons, press_pulse, release_pulse); end
        wait_edges(1);
        checks++; if (press_pulse !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL press_after got=%b/%b exp=0000/0", press_pulse, busy); end
    endtask

    task automatic test_bounce();
        int p0;
        logic [4:0] pat;
        pat = 5'b10101;
        do_reset(4'b0000);
        p0 = press_cnt;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                checks++; if (busy !== 1'b0 || debounced_buttons !== 4'b0000) begin failures++; $display("FAIL bounce_abort got=%b/%b exp=0/0000", busy, debounced_buttons); end
            end
            real_buttons = {3'b000, pat[i]};
            wait_edges(1);
        end
        wait_edges(5);
        checks++; if (debounced_buttons !== 4'b0000 || press_pulse !== 4'b0000) begin failures++; $display("FAIL bounce_early got=%b/%b exp=0000/0000", debounced_buttons, press_pulse); end
        wait_edges(1);
        checks++; if (debounced_buttons !== 4'b0001 || press_pulse !== 4'b0001) begin failures++; $display("FAIL bounce_commit got=%b/%b exp=0001/0001", debounced_buttons, press_pulse); end
        wait_edges(3);
        checks++; if (press_cnt - p0 !== 1) begin failures++; $display("FAIL bounce_count got=%0d exp=1", press_cnt - p0); end
    endtask

    task automatic test_release();
        int r0;
        do_reset(4'b0000);
        real_buttons = 4'b0010;
        wait_edges(10);
        checks++; if (debounced_buttons !== 4'b0010) begin failures++; $display("FAIL release_setup got=%b exp=0010", debounced_buttons); end
        r0 = release_cnt;
        real_buttons = 4'b0000;
        wait_edges(3);
        checks++; if (busy !== 1'b1 || active_idx !== 2'd1) begin failures++; $display("FAIL release_grant got=%b/%0d exp=1/1", busy, active_idx); end
        wait_edges(3);
        checks++; if (debounced_buttons !== 4'b0010 || release_pulse !== 4'b0000) begin failures++; $display("FAIL release_early got=%b/%b exp=0010/0000", debounced_buttons, release_pulse); end
        wait_edges(1);
        checks++; if (debounced_buttons !== 4'b0000 || release_pulse !== 4'b0010 || press_pulse !== 4'b0000) begin failures++; $display("FAIL release_commit got=%b/%b/%b exp=0000/0010/0000", debounced_buttons, release_pulse, press_pulse); end
        wait_edges(1);
        checks++; if (release_pulse !== 4'b0000) begin failures++; $display("FAIL release_after got=%b exp=0000", release_pulse); end
        wait_edges(2);
        checks++; if (release_cnt - r0 !== 1) begin failures++; $display("FAIL release_count got=%0d exp=1", release_cnt - r0); end
    endtask

    task automatic test_contention();
        int p0;
        p0 = press_cnt;
        real_buttons = 4'b1010;
        wait_edges(3);
        checks++; if (busy !== 1'b1 || active_idx !== 2'd3) begin failures++; $display("FAIL cont_grant3 got=%b/%0d exp=1/3", busy, active_idx); end
        wait_edges(4);
        checks++; if (press_pulse !== 4'b1000 || debounced_buttons !== 4'b1000) begin failures++; $display("FAIL cont_commit3 got=%b/%b exp=1000/1000", press_pulse, debounced_buttons); end
        wait_edges(1);
        checks++; if (busy !== 1'b1 || active_idx !== 2'd1 || press_pulse !== 4'b0000) begin failures++; $display("FAIL cont_grant1 got=%b/%0d/%b exp=1/1/0000", busy, active_idx, press_pulse); end
        for (int i = 0; i < 3; i++) begin
            wait_edges(1);
            checks++; if (press_pulse !== 4'b0000) begin failures++; $display("FAIL cont_gap%0d got=%b exp=0000", i, press_pulse); end
        end
        wait_edges(1);
        checks++; if (press_pulse !== 4'b0010 || debounced_buttons !== 4'b1010) begin failures++; $display("FAIL cont_commit1 got=%b/%b exp=0010/1010", press_pulse, debounced_buttons); end
        wait_edges(3);
        checks++; if (press_cnt - p0 !== 2 || busy !== 1'b0) begin failures++; $display("FAIL cont_end got=%0d/%b exp=2/0", press_cnt - p0, busy); end
    endtask

    task automatic test_reset_mid();
        int p0;
        do_reset(4'b0000);
        p0 = press_cnt;
        real_buttons = 4'b0001;
        wait_edges(5);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || debounced_buttons !== 4'b0000) begin failures++; $display("FAIL mid_async got=%b/%b exp=0/0000", busy, debounced_buttons); end
        wait_edges(1);
        rst = 1'b1;
        wait_edges(2);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_pre_grant busy=%b exp=0", busy); end
        wait_edges(1);
        checks++; if (busy !== 1'b1 || active_idx !== 2'd0) begin failures++; $display("FAIL mid_regrant got=%b/%0d exp=1/0", busy, active_idx); end
        wait_edges(3);
        checks++; if (debounced_buttons !== 4'b0000 || press_pulse !== 4'b0000) begin failures++; $display("FAIL mid_early got=%b/%b exp=0000/0000", debounced_buttons, press_pulse); end
        wait_edges(1);
        checks++; if (debounced_buttons !== 4'b0001 || press_pulse !== 4'b0001) begin failures++; $display("FAIL mid_commit got=%b/%b exp=0001/0001", debounced_buttons, press_pulse); end
        wait_edges(3);
        checks++; if (press_cnt - p0 !== 1) begin failures++; $display("FAIL mid_count got=%0d exp=1", press_cnt - p0); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_contention();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
Shares a single debounce timer among N_BUTTONS raw button inputs using a round-robin scheduler, so large button panels do not need one counter per button. It synchronizes each input and detects inputs whose value differs from the debounced value. One candidate at a time is granted the timer, and the new value is committed only if it holds for DEBOUNCE_TIME cycles. It sits between the board button pins and the game/control FSMs, and emits a level and one-cycle press/release pulses per button.

Parameters:
N_BUTTONS, 4, number of button inputs (>=1)
DEBOUNCE_TIME, 100, cycles the new level must hold before commit (>=2; 100 = 20 ms at 5 kHz)
CNT_W (localparam), $clog2(DEBOUNCE_TIME+1), timer width
IDX_W (localparam), max(1,$clog2(N_BUTTONS)), index width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
real_buttons  input  N_BUTTONS  raw, asynchronous, bouncing button levels
debounced_buttons  output  N_BUTTONS  committed stable levels, registered
press_pulse  output  N_BUTTONS  1-cycle pulse on committed 0->1
release_pulse  output  N_BUTTONS  1-cycle pulse on committed 1->0
busy  output  1  high while the timer is granted (state COUNT)
active_idx  output  IDX_W  index currently granted; valid only when busy=1, else 0

Behaviour:
- Reset (rst=0, asynchronous): sync flops, debounced_buttons, pulses, busy, active_idx, timer and rr_ptr all 0. State IDLE. Asserting reset mid-COUNT aborts the count, with no commit and no pulse.
- Synchronizer: 2-FF per bit, real_buttons -> sync1 -> sync2. Only sync2 is used downstream.
- mismatch[i] = sync2[i] ^ debounced_buttons[i].
- State IDLE:
  - If any mismatch is set, grant the first set index searching from rr_ptr upward with wrap.
  - On the grant edge: latch idx and target = sync2[idx], timer=0, state COUNT.
  - If no mismatch is set, stay in IDLE.
- State COUNT, each edge:
  - If sync2[idx] != target: abort. State IDLE, rr_ptr = idx+1 mod N, no output change.
  - Else if timer == DEBOUNCE_TIME-1: commit. debounced_buttons[idx] <= target; press_pulse[idx] <= target; release_pulse[idx] <= ~target; state IDLE; rr_ptr = idx+1 mod N.
  - Else timer++.
- Pulses are registered and high exactly one cycle after the commit edge. At most one pulse bit is set in any cycle, and never both press and release.
- Latency: a clean edge on an idle scheduler is first sampled on edge 1. It is granted on edge 3 and committed on edge DEBOUNCE_TIME+3. The pulse is visible for the cycle after that edge.
- Re-grant: the scheduler returns to IDLE for at least one cycle after every commit or abort before the next grant.
- Fairness: a persistently mismatched button is granted within N_BUTTONS-1 other grants. Worst-case commit latency is N_BUTTONS*(DEBOUNCE_TIME+1)+2 cycles.
- A non-granted input that bounces and returns to its debounced value before being granted produces nothing.
- If a committed value equals the current sync2, no further grant occurs for that button.
- Wrap: rr_ptr wraps from N_BUTTONS-1 to 0. With N_BUTTONS=1, rr_ptr stays 0.

Test Plan:
- Reset: N=4, DEBOUNCE_TIME=4. Hold rst=0 with real_buttons=4'b1111 -> all outputs 0 and busy=0. Release rst, hold the input -> buttons granted 0,1,2,3 in order, one debounced bit set per 5-6 cycles, four press pulses total.
- Clean press: real_buttons[2] 0->1 with all others 0 -> busy on edge 3, active_idx=2. debounced_buttons[2]=1 and press_pulse=4'b0100 for one cycle on edge 7. No release pulse.
- Bounce: real_buttons[0] toggles 1,0,1,0 on consecutive cycles, then holds 1 -> aborts cause no output change. Exactly one press_pulse[0], committed 7 cycles after the final 0->1 if the timer is idle.
- Contention: buttons 1 and 3 rise together with rr_ptr=2 -> 3 is granted first, then 1. Pulses are 5 or more cycles apart and never overlap.
- Release: debounced bit 1=1, real_buttons[1] 1->0 and held -> release_pulse=4'b0010 for one cycle on edge 7. debounced_buttons[1]=0.
- Reset mid-operation: rst=0 for 1 cycle while busy with timer=2 -> busy=0 immediately (asynchronous), no pulse. After release, the still-held input is re-debounced from scratch.
